// File: rtl/alu_seq.sv
// alu_seq: multi-byte operation sequencer for the WIDTH-bit ALU.
//
// Accepts one wide request of up to BYTES slices. It drives the ALU one slice
// per cycle: the first slice uses the first-byte opcode and later slices use
// the chained opcode, so the ALU's internal carry links the slices. Each
// slice result is written into a wide result register, the flags are merged,
// and one response is returned over a valid/ready handshake.
//
// Optional feature: define ALU_SEQ_ABORT_EN to add the `abort` input, which
// cuts an operation short while it is in EXEC.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_op_first/chain  ALU opcode for the first slice / the remaining slices
//   req_len             slice count, clamped to 1..BYTES
//   req_msb_first       0: slices 0..L-1, 1: slices L-1..0
//   req_lhs/rhs         wide operands, slice k = [k*WIDTH +: WIDTH]
//   alu_*               registered ALU drive; alu_assert_bus is active-low
//   alu_result/flags    ALU combinational result, {lcarry,acarry,zero,sign,ovf}
//   resp_valid/ready    response handshake
//   resp_result/flags   assembled result (slices >= L are zero), merged flags
//   abort               (ALU_SEQ_ABORT_EN only) end EXEC early

module alu_seq #(
    parameter int WIDTH = 8,
    parameter int BYTES = 4,
    parameter int LEN_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_op_first,
    input  logic [3:0]               req_op_chain,
    input  logic [LEN_W-1:0]         req_len,
    input  logic                     req_msb_first,
    input  logic [WIDTH*BYTES-1:0]   req_lhs,
    input  logic [WIDTH*BYTES-1:0]   req_rhs,
    output logic [3:0]               alu_operation,
    output logic [WIDTH-1:0]         alu_lhs,
    output logic [WIDTH-1:0]         alu_rhs,
    output logic                     alu_assert_bus,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic [4:0]               alu_flags,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH*BYTES-1:0]   resp_result,
    output logic [4:0]               resp_flags
`ifdef ALU_SEQ_ABORT_EN
    ,
    input  logic                     abort
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
    localparam logic [LEN_W-1:0] BYTES_L = LEN_W'(BYTES);

    state_e                   state_q;
    logic [3:0]               op_chain_q;
    logic                     msb_first_q;
    logic [WIDTH*BYTES-1:0]   lhs_q;
    logic [WIDTH*BYTES-1:0]   rhs_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         cnt_q;
    logic [WIDTH*BYTES-1:0]   result_q;
    logic [4:0]               flags_q;
    logic                     zero_q;
    logic                     sign_q;
    logic                     ovf_q;
    logic                     req_ready_q;
    logic                     resp_valid_q;
    logic [3:0]               alu_op_q;
    logic [WIDTH-1:0]         alu_lhs_q;
    logic [WIDTH-1:0]         alu_rhs_q;
    logic                     alu_bus_q;

    logic [LEN_W-1:0]         len_d;
    logic [LEN_W-1:0]         first_s;
    logic [LEN_W-1:0]         s_cur;
    logic [LEN_W-1:0]         cnt_nx;
    logic [LEN_W-1:0]         s_nx;
    logic                     last;
    logic                     at_top;
    int unsigned              base_first;
    int unsigned              base_cur;
    int unsigned              base_nx;

    always_comb begin
        len_d = req_len;
        if (req_len == '0) begin
            len_d = ONE_L;
        end else if (req_len > BYTES_L) begin
            len_d = BYTES_L;
        end
        first_s    = req_msb_first ? (len_d - ONE_L) : '0;
        s_cur      = msb_first_q ? (len_q - ONE_L - cnt_q) : cnt_q;
        cnt_nx     = cnt_q + ONE_L;
        s_nx       = msb_first_q ? (len_q - ONE_L - cnt_nx) : cnt_nx;
        last       = (cnt_q == (len_q - ONE_L));
        // sign/overflow belong to the most significant slice, which is not
        // the final cycle when the request runs MSB first.
        at_top     = (s_cur == (len_q - ONE_L));
        base_first = 32'(first_s) * WIDTH;
        base_cur   = 32'(s_cur) * WIDTH;
        base_nx    = 32'(s_nx) * WIDTH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_chain_q   <= '0;
            msb_first_q  <= 1'b0;
            lhs_q        <= '0;
            rhs_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            zero_q       <= 1'b0;
            sign_q       <= 1'b0;
            ovf_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            alu_op_q     <= '0;
            alu_lhs_q    <= '0;
            alu_rhs_q    <= '0;
            alu_bus_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_chain_q  <= req_op_chain;
                        msb_first_q <= req_msb_first;
                        lhs_q       <= req_lhs;
                        rhs_q       <= req_rhs;
                        len_q       <= len_d;
                        cnt_q       <= '0;
                        result_q    <= '0;
                        zero_q      <= 1'b1;
                        sign_q      <= 1'b0;
                        ovf_q       <= 1'b0;
                        req_ready_q <= 1'b0;
                        // ALU drive is registered, so slice 0 of the
                        // sequence is presented straight off the accept edge.
                        alu_op_q    <= req_op_first;
                        alu_lhs_q   <= req_lhs[base_first +: WIDTH];
                        alu_rhs_q   <= req_rhs[base_first +: WIDTH];
                        alu_bus_q   <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
`ifdef ALU_SEQ_ABORT_EN
                    if (abort) begin
                        // The slice on the bus this cycle is discarded.
                        flags_q      <= {2'b00, zero_q, 2'b00};
                        resp_valid_q <= 1'b1;
                        alu_op_q     <= '0;
                        alu_lhs_q    <= '0;
                        alu_rhs_q    <= '0;
                        alu_bus_q    <= 1'b1;
                        state_q      <= RESP;
                    end else
`endif
                    begin
                        result_q[base_cur +: WIDTH] <= alu_result;
                        zero_q <= zero_q & alu_flags[2];
                        if (at_top) begin
                            sign_q <= alu_flags[1];
                            ovf_q  <= alu_flags[0];
                        end
                        if (last) begin
                            flags_q <= {alu_flags[4], alu_flags[3],
                                        zero_q & alu_flags[2],
                                        at_top ? alu_flags[1] : sign_q,
                                        at_top ? alu_flags[0] : ovf_q};
                            resp_valid_q <= 1'b1;
                            alu_op_q     <= '0;
                            alu_lhs_q    <= '0;
                            alu_rhs_q    <= '0;
                            alu_bus_q    <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            cnt_q     <= cnt_nx;
                            alu_op_q  <= op_chain_q;
                            alu_lhs_q <= lhs_q[base_nx +: WIDTH];
                            alu_rhs_q <= rhs_q[base_nx +: WIDTH];
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_result    = result_q;
    assign resp_flags     = flags_q;
    assign alu_operation  = alu_op_q;
    assign alu_lhs        = alu_lhs_q;
    assign alu_rhs        = alu_rhs_q;
    assign alu_assert_bus = alu_bus_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, table-driven bench for alu_seq. A small behavioural
// ALU with a clocked carry/link state stands in for the real ALU.
// Opcodes used by the stand-in: 1 ADD, 2 ADC, 3 SHR (0 in, bit0 -> lcarry),
// 4 RCR (lcarry in at msb, bit0 -> lcarry).

module tb_alu_seq;
    localparam int WIDTH = 8;
    localparam int BYTES = 4;
    localparam int LEN_W = 3;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_ADC = 4'h2;
    localparam logic [3:0] OP_SHR = 4'h3;
    localparam logic [3:0] OP_RCR = 4'h4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    req_valid;
    logic                    req_ready;
    logic [3:0]              req_op_first;
    logic [3:0]              req_op_chain;
    logic [LEN_W-1:0]        req_len;
    logic                    req_msb_first;
    logic [WIDTH*BYTES-1:0]  req_lhs;
    logic [WIDTH*BYTES-1:0]  req_rhs;
    logic [3:0]              alu_operation;
    logic [WIDTH-1:0]        alu_lhs;
    logic [WIDTH-1:0]        alu_rhs;
    logic                    alu_assert_bus;
    logic [WIDTH-1:0]        alu_result;
    logic [4:0]              alu_flags;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [WIDTH*BYTES-1:0]  resp_result;
    logic [4:0]              resp_flags;
`ifdef ALU_SEQ_ABORT_EN
    logic                    abort;
`endif

    alu_seq #(.WIDTH(WIDTH), .BYTES(BYTES), .LEN_W(LEN_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op_first   (req_op_first),
        .req_op_chain   (req_op_chain),
        .req_len        (req_len),
        .req_msb_first  (req_msb_first),
        .req_lhs        (req_lhs),
        .req_rhs        (req_rhs),
        .alu_operation  (alu_operation),
        .alu_lhs        (alu_lhs),
        .alu_rhs        (alu_rhs),
        .alu_assert_bus (alu_assert_bus),
        .alu_result     (alu_result),
        .alu_flags      (alu_flags),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_result    (resp_result),
        .resp_flags     (resp_flags)
`ifdef ALU_SEQ_ABORT_EN
        ,
        .abort          (abort)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in ALU
    logic       ac_st = 1'b0;
    logic       lc_st = 1'b0;
    logic [7:0] m_res;
    logic       m_ac, m_lc, m_ovf;
    logic [8:0] sum;

    always_comb begin
        m_res = '0;
        m_ac  = ac_st;
        m_lc  = lc_st;
        m_ovf = 1'b0;
        sum   = '0;
        case (alu_operation)
            OP_ADD, OP_ADC: begin
                sum   = {1'b0, alu_lhs} + {1'b0, alu_rhs}
                      + {8'b0, (alu_operation == OP_ADC) ? ac_st : 1'b0};
                m_res = sum[7:0];
                m_ac  = sum[8];
                m_ovf = (alu_lhs[7] == alu_rhs[7]) && (m_res[7] != alu_lhs[7]);
            end
            OP_SHR: begin
                m_res = {1'b0, alu_lhs[7:1]};
                m_lc  = alu_lhs[0];
            end
            OP_RCR: begin
                m_res = {lc_st, alu_lhs[7:1]};
                m_lc  = alu_lhs[0];
            end
            default: ;
        endcase
        alu_result = m_res;
        alu_flags  = {m_lc, m_ac, (m_res == 8'h00), m_res[7], m_ovf};
    end

    always @(posedge clk) begin
        if (!alu_assert_bus) begin
            ac_st <= m_ac;
            lc_st <= m_lc;
        end
    end

    // Bus activity log, one entry per EXEC cycle
    logic [7:0] lhs_log[$];
    logic [3:0] op_log[$];
    always @(negedge clk) begin
        if (rst_n && !alu_assert_bus) begin
            lhs_log.push_back(alu_lhs);
            op_log.push_back(alu_operation);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  opf;
        logic [3:0]  opc;
        logic [2:0]  len;
        logic        msb;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [31:0] exp_res;
        logic [4:0]  exp_flags;
        int          cyc;
        logic [7:0]  first_lhs;
        logic [7:0]  last_lhs;
    } vec_t;

    vec_t vecs[6];

    task automatic send(input logic [3:0] opf, input logic [3:0] opc, input logic [2:0] len,
                        input logic msb, input logic [31:0] lhs, input logic [31:0] rhs);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1'b1);
        req_op_first  = opf;
        req_op_chain  = opc;
        req_len       = len;
        req_msb_first = msb;
        req_lhs       = lhs;
        req_rhs       = rhs;
        req_valid     = 1'b1;
        lhs_log.delete();
        op_log.delete();
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Counts negedges with resp_valid low after accept; equals L.
    task automatic wait_resp(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (resp_valid) break;
            n++;
        end
        if (!resp_valid) chk("resp_timeout", 0, 1);
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("resp_valid_drop", resp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] held;

        //            opf     opc     len   msb   lhs           rhs           result        flags     cyc first  last
        vecs[0] = '{OP_ADD, OP_ADC, 3'd2, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 5'b00000, 2, 8'hFF, 8'h00};
        vecs[1] = '{OP_ADD, OP_ADC, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b01100, 4, 8'hFF, 8'hFF};
        vecs[2] = '{OP_SHR, OP_RCR, 3'd2, 1'b1, 32'h0000_0181, 32'h0000_0000, 32'h0000_00C0, 5'b11000, 2, 8'h01, 8'h81};
        vecs[3] = '{OP_ADD, OP_ADC, 3'd0, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h0000_0089, 5'b10011, 1, 8'h78, 8'h78};
        vecs[4] = '{OP_ADD, OP_ADC, 3'd7, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 5'b10000, 4, 8'h78, 8'h12};
        vecs[5] = '{OP_ADD, OP_ADC, 3'd3, 1'b0, 32'hAA80_0001, 32'hFF80_FFFF, 32'h0001_0000, 5'b11001, 3, 8'h01, 8'h80};

        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op_first = '0; req_op_chain = '0; req_len = '0; req_msb_first = 1'b0;
        req_lhs = '0; req_rhs = '0;
`ifdef ALU_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_result", resp_result, 32'h0);
        chk("rst_resp_flags", resp_flags, 5'h0);
        chk("rst_alu_op", alu_operation, 4'h0);
        chk("rst_alu_lhs", alu_lhs, 8'h0);
        chk("rst_alu_rhs", alu_rhs, 8'h0);
        chk("rst_alu_bus", alu_assert_bus, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].opf, vecs[i].opc, vecs[i].len, vecs[i].msb, vecs[i].lhs, vecs[i].rhs);
            wait_resp(n);
            chk($sformatf("v%0d_latency", i), n, vecs[i].cyc);
            chk($sformatf("v%0d_exec_cycles", i), lhs_log.size(), vecs[i].cyc);
            chk($sformatf("v%0d_result", i), resp_result, vecs[i].exp_res);
            chk($sformatf("v%0d_flags", i), resp_flags, vecs[i].exp_flags);
            chk($sformatf("v%0d_first_lhs", i), lhs_log[0], vecs[i].first_lhs);
            chk($sformatf("v%0d_last_lhs", i), lhs_log[lhs_log.size()-1], vecs[i].last_lhs);
            chk($sformatf("v%0d_first_op", i), op_log[0], vecs[i].opf);
            chk($sformatf("v%0d_last_op", i), op_log[op_log.size()-1],
                (vecs[i].cyc > 1) ? vecs[i].opc : vecs[i].opf);
            chk($sformatf("v%0d_bus_idle", i), alu_assert_bus, 1'b1);
            chk($sformatf("v%0d_req_ready_resp", i), req_ready, 1'b0);
            release_resp();
        end

        // Backpressure: response held, stray requests ignored
        send(OP_ADD, OP_ADC, 3'd2, 1'b0, 32'h0000_00FF, 32'h0000_0001);
        wait_resp(n);
        held = resp_result;
        chk("bp_result", held, 32'h0000_0100);
        req_valid = 1'b1;
        req_lhs   = 32'h5555_5555;
        req_len   = 3'd3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid_held", resp_valid, 1'b1);
            chk("bp_result_stable", resp_result, held);
            chk("bp_req_ready", req_ready, 1'b0);
            chk("bp_bus_idle", alu_assert_bus, 1'b1);
        end
        req_valid = 1'b0;
        release_resp();
        chk("bp_no_accept", alu_assert_bus, 1'b1);
        chk("bp_idle_ready", req_ready, 1'b1);

        // Reset during EXEC cycle 1 of a 4-slice request
        send(OP_ADD, OP_ADC, 3'd4, 1'b0, 32'h0102_0304, 32'h1010_1010);
        @(posedge clk);
        @(negedge clk);
        chk("mid_exec_bus", alu_assert_bus, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_req_ready", req_ready, 1'b1);
        chk("mrst_resp_valid", resp_valid, 1'b0);
        chk("mrst_resp_result", resp_result, 32'h0);
        chk("mrst_resp_flags", resp_flags, 5'h0);
        chk("mrst_alu_op", alu_operation, 4'h0);
        chk("mrst_alu_lhs", alu_lhs, 8'h0);
        chk("mrst_alu_rhs", alu_rhs, 8'h0);
        chk("mrst_alu_bus", alu_assert_bus, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef ALU_SEQ_ABORT_EN
        // Abort in EXEC cycle 2: slices 0-1 kept, 2-3 zero, flags cleared
        send(OP_ADD, OP_ADC, 3'd4, 1'b0, 32'h4433_2211, 32'h0101_0101);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", resp_valid, 1'b1);
        chk("abort_result", resp_result, 32'h0000_2312);
        chk("abort_flags", resp_flags, 5'h0);
        chk("abort_bus", alu_assert_bus, 1'b1);
        release_resp();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-byte operation sequencer for the WIDTH-bit ALU.
- Accepts one wide request of up to BYTES bytes and drives the ALU one byte per cycle.
- Uses the first-byte opcode on the first slice and the chained opcode on later slices, so the ALU's internal carry links the bytes.
- Collects byte results into a wide result, merges flags, and returns one response through a valid/ready handshake. It sits between the control unit and the ALU.

Parameters:
- WIDTH, 8, ALU datapath width in bits.
- BYTES, 4, maximum slices per request (2..7).
- LEN_W, 3, width of req_len; must hold BYTES.

Ports:
- clk  input  1  system clock (also the ALU clock domain)
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_op_first  input  4  ALU operation for the first slice
- req_op_chain  input  4  ALU operation for slices 2..len
- req_len  input  LEN_W  slice count
- req_msb_first  input  1  0: slice order 0..len-1; 1: slice order len-1..0 (right shifts)
- req_lhs  input  WIDTH*BYTES  left operand, slice k = bits [k*WIDTH +: WIDTH]
- req_rhs  input  WIDTH*BYTES  right operand
- alu_operation  output  4  opcode to ALU
- alu_lhs  output  WIDTH  ALU left slice
- alu_rhs  output  WIDTH  ALU right slice
- alu_assert_bus  output  1  active-low ALU bus assert
- alu_result  input  WIDTH  ALU combinational result
- alu_flags  input  5  {lcarry, acarry, zero, sign, overflow}
- resp_valid  output  1  response present
- resp_ready  input  1  consumer takes response
- resp_result  output  WIDTH*BYTES  assembled result; slices at and above len are zero
- resp_flags  output  5  merged flags, same order as alu_flags

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1; resp_valid=0; resp_result=0; resp_flags=0.
  - alu_operation=0; alu_lhs=0; alu_rhs=0; alu_assert_bus=1.
- States IDLE -> EXEC -> RESP -> IDLE. Single outstanding request.
- IDLE:
  - req_ready=1.
  - When req_valid=1 at a clk edge, latch op_first, op_chain, msb_first, lhs and rhs, plus the effective length L.
  - L is req_len clamped to the range 1..BYTES: 0 becomes 1; values above BYTES become BYTES.
  - Clear the result register, load slice index i, and go to EXEC.
- EXEC:
  - Lasts exactly L cycles. req_ready=0; alu_assert_bus=0.
  - Cycle n (0-based) drives slice s = n when msb_first=0, or s = L-1-n when msb_first=1. alu_lhs and alu_rhs carry slice s.
  - alu_operation = op_first when n=0, op_chain otherwise.
  - At the end of each cycle, sample alu_result into result slice s and sample alu_flags.
- Flag merge:
  - zero = AND of the sampled zero bits across all L slices.
  - acarry and lcarry = values sampled on the final EXEC cycle.
  - sign and overflow = values sampled on the cycle that processed slice L-1.
- Leaving EXEC: after the last slice go to RESP, with alu_assert_bus=1, alu_operation=0, and alu_lhs=alu_rhs=0.
- RESP:
  - resp_valid=1; resp_result and resp_flags stay stable until resp_ready=1 at a clk edge, then return to IDLE.
  - req_ready=0 in RESP, so back-to-back requests carry one idle cycle minimum.
- Latency: request accepted at edge T; resp_valid rises at edge T+L. The earliest next accept is at edge T+L+2 when resp_ready is held at 1.
- Boundary conditions:
  - req_valid is ignored outside IDLE.
  - resp_ready is ignored outside RESP.
  - rst_n asserted mid-EXEC or mid-RESP aborts immediately to the reset values above; the ALU carry state is not restored.

Optional Feature:
- Macro: ALU_SEQ_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 at a clk edge in EXEC ends the operation at that edge and enters RESP.
  - Completed slices are kept; the remaining slices are zero.
  - resp_flags is forced to 0 except zero = AND over the completed slices.
  - abort has no effect in IDLE or RESP.
- Not defined: no abort port; EXEC always runs L cycles.

Test Plan:
- Add across bytes: op_first=ADD, op_chain=ADC, len=2, lhs=0x00FF, rhs=0x0001 -> resp_result=0x0100; zero=0, acarry=0; resp_valid rises 2 cycles after accept.
- Full carry-out: same ops, len=4, lhs=0xFFFFFFFF, rhs=0x00000001 -> resp_result=0; zero=1; acarry=1.
- Right shift MSB first: len=2, msb_first=1, lhs=0x0181 -> alu_lhs sequence 0x01 then 0x81, resp_result=0x00C0, lcarry=1.
- Length clamp: req_len=0 -> 1 EXEC cycle; req_len=7 with BYTES=4 -> 4 EXEC cycles; unused slices zero.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and result stable; req_valid during that time is ignored, with req_ready=0.
- Reset mid-EXEC: drop rst_n in EXEC cycle 1 of len=4 -> all outputs at reset values immediately. With ALU_SEQ_ABORT_EN, abort in cycle 2 -> RESP with slices 0-1 valid and slices 2-3 zero.
